// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the five-stage pipeline controller:
// opcodes, instruction field positions, FSM states, scoreboard slot.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Bit 0 is the MSB of the instruction word.
    localparam int OPC_MSB = 0;
    localparam int OPC_LSB = 3;
    localparam int RS_MSB  = 4;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 9;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 12;
    localparam int FN_MSB  = 10;
    localparam int FN_LSB  = 15;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        DRAIN     = 2'd2,
        HALT_DONE = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dst;
        logic             mem;
    } sb_slot_t;

    localparam int SB_SLOT_W = 1 + REG_W + 1;

endpackage

// File: rtl/pipeline_controller_decode.sv
// Instruction class decoder: which registers an ID-stage instruction
// reads, which one it writes, and whether it is a memory op or HALT.
module instr_class_decode #(
    parameter int         REG_BITS  = 3,
    parameter logic [3:0] HALT_CODE = pipe_ctrl_pkg::OP_HALT
) (
    input  logic [0:15]         instruc,
    output logic [REG_BITS-1:0] rs,
    output logic [REG_BITS-1:0] rt,
    output logic                reads_rs,
    output logic                reads_rt,
    output logic                wr_en,
    output logic [REG_BITS-1:0] dst,
    output logic                is_mem,
    output logic                is_halt
);
    import pipe_ctrl_pkg::*;

    logic [3:0] op;
    logic       wr_raw;
    logic       unused_funct;

    assign op           = instruc[OPC_MSB:OPC_LSB];
    assign rs           = instruc[RS_MSB:RS_LSB];
    assign rt           = instruc[RT_MSB:RT_LSB];
    assign unused_funct = ^instruc[FN_MSB:FN_LSB];

    // Classify the opcode; a write to r0 is treated as no write.
    always_comb begin
        reads_rs = 1'b1;
        reads_rt = 1'b0;
        wr_raw   = 1'b1;
        dst      = rt;
        is_mem   = 1'b0;
        is_halt  = 1'b0;
        if (op == HALT_CODE) begin
            reads_rs = 1'b0;
            wr_raw   = 1'b0;
            is_halt  = 1'b1;
        end else begin
            case (op)
                OP_RTYPE: begin
                    reads_rt = 1'b1;
                    dst      = instruc[RD_MSB:RD_LSB];
                end
                OP_LW: begin
                    is_mem = 1'b1;
                end
                OP_SW: begin
                    reads_rt = 1'b1;
                    wr_raw   = 1'b0;
                    is_mem   = 1'b1;
                end
                OP_BEQ: begin
                    reads_rt = 1'b1;
                    wr_raw   = 1'b0;
                end
                OP_J: begin
                    reads_rs = 1'b0;
                    wr_raw   = 1'b0;
                end
                default: begin
                end
            endcase
        end
        wr_en = wr_raw && (dst != '0);
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: EX/MEM destination scoreboard, RAW hazard detect,
// memory-handshake freeze, branch flush and HALT drain.
module pipeline_controller #(
    parameter int         REG_BITS = 3,
    parameter logic [3:0] OP_HALT  = pipe_ctrl_pkg::OP_HALT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:15] instruc,
    input  logic        id_valid,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_en,
    output logic        stall,
    output logic        mem_req,
    output logic        halted
);
    import pipe_ctrl_pkg::*;

    ctrl_state_t state, state_n;

    logic [SB_SLOT_W-1:0] ex_q, mem_q;
    sb_slot_t             ex_s, mem_s, id_slot;

    logic [REG_BITS-1:0] rs, rt, dst;
    logic reads_rs, reads_rt, wr_en, is_mem, is_halt;
    logic hit_rs, hit_rt, hazard, freeze;

    instr_class_decode #(
        .REG_BITS  (REG_BITS),
        .HALT_CODE (OP_HALT)
    ) u_decode (
        .instruc  (instruc),
        .rs       (rs),
        .rt       (rt),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt),
        .wr_en    (wr_en),
        .dst      (dst),
        .is_mem   (is_mem),
        .is_halt  (is_halt)
    );

    assign ex_s  = sb_slot_t'(ex_q);
    assign mem_s = sb_slot_t'(mem_q);

    assign id_slot.wr  = wr_en;
    assign id_slot.dst = dst;
    assign id_slot.mem = is_mem;

    // RAW check of the ID sources against pending EX/MEM writes.
    always_comb begin
        hit_rs = reads_rs && (rs != '0) &&
                 ((ex_s.wr && ex_s.dst == rs) ||
                  (mem_s.wr && mem_s.dst == rs));
        hit_rt = reads_rt && (rt != '0) &&
                 ((ex_s.wr && ex_s.dst == rt) ||
                  (mem_s.wr && mem_s.dst == rt));
        hazard = id_valid && (hit_rs || hit_rt);
        freeze = mem_s.mem && !mem_ready;
    end

    assign mem_req = mem_s.mem && (state != HALT_DONE);

    // Priority freeze > branch > hazard > normal, plus halt sequencing.
    always_comb begin
        state_n     = state;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        stall       = 1'b0;
        halted      = 1'b0;
        unique case (state)
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    pipe_en = 1'b0;
                    state_n = MEM_WAIT;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_n     = RUN;
                end else if (hazard) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    stall       = 1'b1;
                    state_n     = RUN;
                end else if (id_valid && is_halt) begin
                    state_n = DRAIN;
                end else begin
                    state_n = RUN;
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                pipe_en     = !freeze;
                if (!(ex_s.wr || ex_s.mem) && !(mem_s.wr || mem_s.mem))
                    state_n = HALT_DONE;
            end
            HALT_DONE: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                pipe_en = 1'b0;
                halted  = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_n;
    end

    // Scoreboard shifts with the pipe; a bubble enters EX as empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (pipe_en) begin
            mem_q <= ex_q;
            if (idex_bubble || !id_valid)
                ex_q <= '0;
            else
                ex_q <= id_slot;
        end
    end

endmodule
